// File: rtl/demux_param_if.sv
// demux_param_if: start/select/VLR request, input element stream and slot outputs of demux_param.
interface demux_param_if #(
    parameter int NUM_OUTPUTS = 20,
    parameter int DATA_WIDTH  = 32,
    parameter int VALID       = 1,
    parameter int MVL         = 32
);
    localparam int SW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int CW = (MVL > 1) ? $clog2(MVL) : 1;
    localparam int W  = DATA_WIDTH + VALID;
    logic                     start;
    logic [SW-1:0]            sel;
    logic [CW:0]              VLR;
    logic [W-1:0]             data_i;
    logic [W*NUM_OUTPUTS-1:0] data_o;
    logic                     busy_o;
    logic                     done_o;
    logic                     err_o;
    logic [CW:0]              cnt_o;
    modport master (output start, sel, VLR, data_i, input data_o, busy_o, done_o, err_o, cnt_o);
    modport slave  (input start, sel, VLR, data_i, output data_o, busy_o, done_o, err_o, cnt_o);
endinterface

// File: rtl/demux_param.sv
// demux_param: steers VLR valid elements of one stream to a selected slot, then returns to idle.
// Define DEMUX_OUTREG_EN to register data_o and delay done_o by one cycle to match it.
module demux_param #(
    parameter int NUM_OUTPUTS = 20,
    parameter int DATA_WIDTH  = 32,
    parameter int VALID       = 1,
    parameter int MVL         = 32
) (
    input logic          clk,
    input logic          rst,
    demux_param_if.slave bus
);
    localparam int SW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int CW = (MVL > 1) ? $clog2(MVL) : 1;
    localparam int W  = DATA_WIDTH + VALID;
    localparam logic [SW:0] LIMIT = (SW+1)'(NUM_OUTPUTS);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t                   state_q;
    logic [SW-1:0]            sel_q;
    logic [CW:0]              vlr_q;
    logic [CW:0]              cnt_q;
    logic                     done_q;
    logic                     err_q;
    logic [W*NUM_OUTPUTS-1:0] data_d;
    wire                      beat = bus.data_i[DATA_WIDTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            vlr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    // An invalid select wins over the empty-vector shortcut
                    if ({1'b0, bus.sel} >= LIMIT) err_q <= 1'b1;
                    else if (bus.VLR == '0) done_q <= 1'b1;
                    else begin
                        state_q <= BUSY;
                        sel_q   <= bus.sel;
                        vlr_q   <= bus.VLR;
                        cnt_q   <= '0;
                    end
                end
                BUSY: if (beat) begin
                    if (cnt_q == vlr_q - 1'b1) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        sel_q   <= '0;
                        vlr_q   <= '0;
                        done_q  <= 1'b1;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_slot
        localparam logic [SW-1:0] IDX = SW'(g);
        assign data_d[g*W +: W] = (state_q == BUSY && beat && sel_q == IDX) ? bus.data_i : '0;
    end
`ifdef DEMUX_OUTREG_EN
    logic [W*NUM_OUTPUTS-1:0] data_q;
    logic                     done_dly_q;
    always_ff @(posedge clk) begin
        data_q     <= rst ? '0 : data_d;
        done_dly_q <= rst ? 1'b0 : done_q;
    end
    assign bus.data_o = data_q;
    assign bus.done_o = done_dly_q;
`else
    assign bus.data_o = data_d;
    assign bus.done_o = done_q;
`endif
    assign bus.busy_o = (state_q == BUSY);
    assign bus.err_o  = err_q;
    assign bus.cnt_o  = cnt_q;
endmodule
